// File: rtl/kp_pkg.sv
// Shared constants, FSM state type and map helpers for the keypad scanner.
package kp_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;
    localparam int MAP_W  = ROWS * COLS;
    localparam int ROW_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        WAIT_REL
    } kp_state_e;

    // True when exactly one key is set in the matrix map.
    function automatic logic map_one_hot(input logic [MAP_W-1:0] m);
        return (m != '0) && ((m & (m - MAP_W'(1))) == '0);
    endfunction

    // Bit position of the (single) set key; the position is {row, col}.
    function automatic logic [CODE_W-1:0] map_index(input logic [MAP_W-1:0] m);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAP_W; i++) begin
            if (m[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the key event outputs seen by the consumer.
interface keypad_scan_if;
    import kp_pkg::*;

    logic [COLS-1:0]   col_in;
    logic [ROWS-1:0]   row_out;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/kp_debounce.sv
// Whole-matrix debounce: a snapshot becomes the stable map after it has
// been seen unchanged for DEBOUNCE_SCANS consecutive frame comparisons.
module kp_debounce
    import kp_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_end,
    input  logic [MAP_W-1:0] snap,
    output logic             map_upd,
    output logic [MAP_W-1:0] map_new
);

    localparam logic [3:0] DEB_C = 4'(DEBOUNCE_SCANS);

    logic [MAP_W-1:0] prev_q, prev_d;
    logic [MAP_W-1:0] stable_q, stable_d;
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic             load;

    // Compare against the previous frame, count stable frames, load the map.
    always_comb begin
        prev_d     = prev_q;
        stable_d   = stable_q;
        stab_cnt_d = stab_cnt_q;
        load       = 1'b0;
        if (frame_end) begin
            prev_d = snap;
            if (snap == prev_q) begin
                if (stab_cnt_q != DEB_C) stab_cnt_d = stab_cnt_q + 4'd1;
                if (stab_cnt_q == DEB_C - 4'd1) begin
                    load     = 1'b1;
                    stable_d = snap;
                end
            end else begin
                stab_cnt_d = '0;
            end
        end
        // A reload with identical contents is not a key event.
        map_upd = load && (snap != stable_q);
        map_new = stable_d;
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            stable_q   <= '0;
            stab_cnt_q <= '0;
        end else begin
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column sampling, debounce and
// single-key press events.
module keypad_scan
    import kp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam int               SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    logic [COLS-1:0]   col_s1_q, col_s1_d;
    logic [COLS-1:0]   col_s2_q, col_s2_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic [MAP_W-1:0]  snap_q, snap_d;
    logic              slot_last;
    logic              frame_end;

    logic              map_upd;
    logic [MAP_W-1:0]  map_new;

    kp_state_e         state_q, state_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    // Synchronize columns, advance slot/row counters, sample the settled row.
    always_comb begin
        col_s1_d  = kp.col_in;
        col_s2_d  = col_s1_q;
        slot_last = (slot_q == SLOT_LAST);
        frame_end = slot_last && (row_idx_q == ROW_LAST);
        slot_d    = slot_last ? '0 : slot_q + SLOT_W'(1);
        row_idx_d = slot_last ? row_idx_q + ROW_W'(1) : row_idx_q;
        snap_d    = snap_q;
        if (slot_last) snap_d[row_idx_q*COLS +: COLS] = ~col_s2_q;
    end

    // Scan path registers; idle columns read high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q  <= '1;
            col_s2_q  <= '1;
            slot_q    <= '0;
            row_idx_q <= '0;
            snap_q    <= '0;
        end else begin
            col_s1_q  <= col_s1_d;
            col_s2_q  <= col_s2_d;
            slot_q    <= slot_d;
            row_idx_q <= row_idx_d;
            snap_q    <= snap_d;
        end
    end

    // snap_d already holds the last row's sample on the frame-end cycle.
    kp_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_end (frame_end),
        .snap      (snap_d),
        .map_upd   (map_upd),
        .map_new   (map_new)
    );

    // Press/release FSM reacting to each change of the stable map.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (map_upd) begin
            case (state_q)
                IDLE: begin
                    if (map_one_hot(map_new)) begin
                        state_d     = PRESSED;
                        key_code_d  = map_index(map_new);
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else if (map_new != '0) begin
                        state_d = WAIT_REL;
                    end
                end
                PRESSED: begin
                    key_held_d = 1'b0;
                    state_d    = (map_new == '0) ? IDLE : WAIT_REL;
                end
                WAIT_REL: begin
                    if (map_new == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.row_out   = ~(ROWS'(1) << row_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a frame-level reference model of debounce and
// press/release events.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] keys = '0;
    logic        bounce_off = 1'b0;
    logic [3:0]  col_drv;

    always #5 clk = ~clk;

    keypad_scan_if kp ();

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    // Physical keypad: a pressed key shorts its column to a driven-low row.
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.row_out[r] && keys[r*4+c] && !bounce_off) col_drv[c] = 1'b0;
    end
    assign kp.col_in = col_drv;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          model_on = 1'b1;
    logic [15:0] frame_map = '0;
    logic [15:0] hist[$];
    int          m_state = 0;
    logic [15:0] m_stable = '0;
    logic        exp_valid = 1'b0;
    logic        exp_held = 1'b0;
    logic [3:0]  exp_code = '0;
    int          pulses = 0;
    logic [3:0]  last_code = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // True if hist[lo..hi] are all the same map (false if lo precedes reset).
    function automatic bit win_eq(input int lo, input int hi);
        if (lo < 0) return 1'b0;
        for (int i = lo + 1; i <= hi; i++)
            if (hist[i] != hist[lo]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(16'h0);
        m_state   = 0;
        m_stable  = '0;
        exp_valid = 1'b0;
        exp_held  = 1'b0;
        exp_code  = '0;
        cyc       = 0;
    endtask

    // One frame of the reference: the map becomes stable when it has been
    // seen in DB+1 consecutive snapshots and that run has just formed.
    task automatic model_frame_end(input logic [15:0] snap);
        int n;
        bit load;
        hist.push_back(snap);
        n = hist.size();
        load = win_eq(n - 1 - DB, n - 1) && !win_eq(n - 2 - DB, n - 2);
        if (load && snap != m_stable) begin
            m_stable = snap;
            if (m_state == 0) begin
                if ($countones(snap) == 1) begin
                    m_state   = 1;
                    exp_valid = 1'b1;
                    exp_held  = 1'b1;
                    for (int i = 0; i < 16; i++) if (snap[i]) exp_code = 4'(i);
                end else if (snap != 0) begin
                    m_state = 2;
                end
            end else if (m_state == 1) begin
                exp_held = 1'b0;
                m_state  = (snap == 0) ? 0 : 2;
            end else begin
                if (snap == 0) m_state = 0;
            end
        end
    endtask

    task automatic cycle_step();
        logic [3:0] exp_row;
        @(posedge clk);
        cyc++;
        exp_valid = 1'b0;
        if (model_on && (cyc % FR == 0)) model_frame_end(frame_map);
        @(negedge clk);
        exp_row = ~(4'b0001 << ((cyc / SD) % 4));
        chk("row_out", 16'(kp.row_out), 16'(exp_row));
        if (kp.key_valid) begin
            pulses++;
            last_code = kp.key_code;
        end
        if (model_on) begin
            chk("key_valid", 16'(kp.key_valid), 16'(exp_valid));
            chk("key_held", 16'(kp.key_held), 16'(exp_held));
            chk("key_code", 16'(kp.key_code), 16'(exp_code));
        end
    endtask

    // Hold a key map for n whole frames, starting at a frame boundary.
    task automatic run_frames(input logic [15:0] map, input int n);
        keys = map;
        frame_map = map;
        repeat (n * FR) cycle_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_row"}, 16'(kp.row_out), 16'h000E);
        chk({tag, "_code"}, 16'(kp.key_code), 16'h0);
        chk({tag, "_valid"}, 16'(kp.key_valid), 16'h0);
        chk({tag, "_held"}, 16'(kp.key_held), 16'h0);
    endtask

    // Assert reset mid-cycle, verify outputs at once and while held, release.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs({tag, "_async"});
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs({tag, "_hold"});
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int len;
        int kind;

        // Power-on reset.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        do_reset("por2");

        // No keys: row scan only, no events.
        pulses = 0;
        run_frames(16'h0000, 4);
        chk("idle_pulses", 16'(pulses), 16'd0);

        // Single clean press of (2,1), then release.
        pulses = 0;
        run_frames(16'h0200, 13);
        chk("press9_pulses", 16'(pulses), 16'd1);
        chk("press9_code", 16'(last_code), 16'h9);
        chk("press9_held", 16'(kp.key_held), 16'h1);
        run_frames(16'h0000, 5);
        chk("rel9_held", 16'(kp.key_held), 16'h0);

        // Bouncing press of (2,1): model paused while contacts chatter.
        model_on = 1'b0;
        pulses = 0;
        keys = 16'h0200;
        for (int i = 0; i < 60; i++) begin
            bounce_off = ((i / 5) % 2) == 1;
            cycle_step();
        end
        bounce_off = 1'b0;
        repeat (4) cycle_step();
        chk("bounce_pulses", 16'(pulses), 16'd0);
        frame_map = 16'h0200;
        repeat (6 * FR) cycle_step();
        chk("bounce_steady_pulses", 16'(pulses), 16'd1);
        chk("bounce_code", 16'(last_code), 16'h9);
        chk("bounce_held", 16'(kp.key_held), 16'h1);
        hist.delete();
        repeat (DB + 1) hist.push_back(16'h0200);
        m_state   = 1;
        m_stable  = 16'h0200;
        exp_held  = 1'b1;
        exp_code  = 4'h9;
        model_on  = 1'b1;
        run_frames(16'h0000, 5);

        // Two keys together: ignored; then (1,2) alone.
        pulses = 0;
        run_frames(16'h8001, 6);
        chk("dual_pulses", 16'(pulses), 16'd0);
        chk("dual_held", 16'(kp.key_held), 16'h0);
        run_frames(16'h0000, 5);
        run_frames(16'h0040, 6);
        chk("press6_pulses", 16'(pulses), 16'd1);
        chk("press6_code", 16'(last_code), 16'h6);
        run_frames(16'h0000, 5);

        // Reset while (0,3) is held: a fresh event follows release of reset.
        run_frames(16'h0008, 5);
        chk("hold3_held", 16'(kp.key_held), 16'h1);
        do_reset("midrst");
        pulses = 0;
        run_frames(16'h0008, 5);
        chk("press3_pulses", 16'(pulses), 16'd1);
        chk("press3_code", 16'(last_code), 16'h3);
        run_frames(16'h0000, 5);

        // Random key maps held for random numbers of frames.
        m = '0;
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 6);
            case (kind)
                0: m = '0;
                1: m = 16'h0001 << $urandom_range(0, 15);
                2: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: m = m;
            endcase
            run_frames(m, len);
        end
        run_frames(16'h0000, 5);
        chk("final_held", 16'(kp.key_held), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
